nios_dct_trace_packer: RTL

Controller for the CPU OCI data-trace compression buffer (30-bit dct_buffer, 4-bit dct_count).
- Shares the buffer between two trace requesters: address trace (A) and data trace (D).
- Packs their 2-bit symbols LSB-first into the buffer.
- Hands full or flushed frames to the trace-memory write port over a valid/ready handshake.
- Sits between the OCI trace sources and the on-chip trace RAM. Exports the live buffer/count for the OCI test bench.

---
 rtl/nios_dct_trace_packer_if.sv | 46 ++++
 rtl/nios_dct_trace_packer.sv | 124 ++++++++++++
 2 files changed

// File: rtl/nios_dct_trace_packer_if.sv
// Bus bundle for the OCI data-trace compression buffer controller.
//   slave  : the packer (receives A/D symbol requests, flush and tw_ready;
//            drives grants, the trace-memory frame and the live buffer view)
//   master : the environment (trace sources, trace RAM, OCI test bench)
// Signals:
//   a_valid/a_ready/a_data/a_nsym : address-trace requester
//   d_valid/d_ready/d_data/d_nsym : data-trace requester
//   flush                         : level request to emit a partial frame
//   tw_valid/tw_ready/tw_data/tw_count : trace-memory write port
//   dct_buffer/dct_count/busy     : live packing state
interface nios_dct_trace_packer_if #(
  parameter int SYM_W    = 2,
  parameter int BUF_SYMS = 15,
  parameter int IN_SYMS  = 8,
  parameter int CNT_W    = 4
);
  localparam int BUF_W = BUF_SYMS * SYM_W;
  localparam int IN_W  = IN_SYMS * SYM_W;

  logic             a_valid;
  logic             a_ready;
  logic [IN_W-1:0]  a_data;
  logic [CNT_W-1:0] a_nsym;
  logic             d_valid;
  logic             d_ready;
  logic [IN_W-1:0]  d_data;
  logic [CNT_W-1:0] d_nsym;
  logic             flush;
  logic             tw_valid;
  logic             tw_ready;
  logic [BUF_W-1:0] tw_data;
  logic [CNT_W-1:0] tw_count;
  logic [BUF_W-1:0] dct_buffer;
  logic [CNT_W-1:0] dct_count;
  logic             busy;

  modport slave (
    input  a_valid, a_data, a_nsym, d_valid, d_data, d_nsym, flush, tw_ready,
    output a_ready, d_ready, tw_valid, tw_data, tw_count, dct_buffer, dct_count, busy
  );

  modport master (
    output a_valid, a_data, a_nsym, d_valid, d_data, d_nsym, flush, tw_ready,
    input  a_ready, d_ready, tw_valid, tw_data, tw_count, dct_buffer, dct_count, busy
  );
endinterface

// File: rtl/nios_dct_trace_packer.sv
// Controller for the OCI data-trace compression buffer.
// Two requesters (address trace A, data trace D) share a 15-symbol buffer.
// Their 2-bit symbols are packed LSB-first; full or flushed frames are handed
// to the trace-memory write port over a valid/ready handshake.
// Ports:
//   clk   : system clock, all state on rising edge
//   reset : asynchronous active-high reset
//   bus   : nios_dct_trace_packer_if.slave (requesters, flush, tw port, live view)
module nios_dct_trace_packer #(
  parameter int SYM_W    = 2,
  parameter int BUF_SYMS = 15,
  parameter int IN_SYMS  = 8,
  parameter int CNT_W    = 4
) (
  input logic                     clk,
  input logic                     reset,
  nios_dct_trace_packer_if.slave  bus
);

  localparam int BUF_W = BUF_SYMS * SYM_W;
  localparam int IN_W  = IN_SYMS * SYM_W;
  localparam logic [CNT_W:0]   FULL_CNT = (CNT_W + 1)'(BUF_SYMS);
  localparam logic [CNT_W-1:0] MAX_IN   = CNT_W'(IN_SYMS);

  typedef enum logic {FILL, EMIT} state_t;

  // Symbol counts above the transfer width are treated as a full transfer.
  function automatic logic [CNT_W-1:0] sat_nsym(input logic [CNT_W-1:0] n);
    return (n > MAX_IN) ? MAX_IN : n;
  endfunction

  // Keep only the first n symbols of data and move them to slot 'at'.
  // Shifting the all-ones mask by the full width yields 0, covering n=0.
  function automatic logic [BUF_W-1:0] place(input logic [IN_W-1:0]  data,
                                             input logic [CNT_W-1:0] n,
                                             input logic [CNT_W-1:0] at);
    logic [IN_W-1:0]  mask;
    logic [BUF_W-1:0] ext;
    mask = {IN_W{1'b1}} >> (IN_W - SYM_W * int'(n));
    ext  = BUF_W'(data & mask);
    return ext << (SYM_W * int'(at));
  endfunction

  state_t           state_q, state_d;
  logic [BUF_W-1:0] buf_q, buf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rr_q, rr_d;     // 1: D has priority on a tie, 0: A

  logic [CNT_W-1:0] n_a, n_d, n_w;
  logic [IN_W-1:0]  data_w;
  logic             pick_d;
  logic [CNT_W:0]   sum;
  logic             a_rdy, d_rdy, tw_vld;

  assign n_a    = sat_nsym(bus.a_nsym);
  assign n_d    = sat_nsym(bus.d_nsym);
  // A lone requester always wins; on a tie the pointer decides.
  assign pick_d = bus.d_valid && (!bus.a_valid || rr_q);
  assign n_w    = pick_d ? n_d : n_a;
  assign data_w = pick_d ? bus.d_data : bus.a_data;
  assign sum    = {1'b0, cnt_q} + {1'b0, n_w};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FILL;
      buf_q   <= '0;
      cnt_q   <= '0;
      rr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    a_rdy   = 1'b0;
    d_rdy   = 1'b0;
    tw_vld  = 1'b0;
    unique case (state_q)
      FILL: begin
        if (bus.flush && (cnt_q != '0)) begin
          state_d = EMIT;
        end else if (bus.a_valid || bus.d_valid) begin
          if (sum <= FULL_CNT) begin
            a_rdy = !pick_d;
            d_rdy = pick_d;
            buf_d = buf_q | place(data_w, n_w, cnt_q);
            cnt_d = sum[CNT_W-1:0];
            rr_d  = !pick_d;
            if (sum == FULL_CNT) state_d = EMIT;
          end else begin
            // Winner keeps its request; it is served once the frame drains.
            state_d = EMIT;
          end
        end
      end
      EMIT: begin
        tw_vld = 1'b1;
        if (bus.tw_ready) begin
          state_d = FILL;
          buf_d   = '0;
          cnt_d   = '0;
        end
      end
      default: state_d = FILL;
    endcase
  end

  assign bus.a_ready    = a_rdy;
  assign bus.d_ready    = d_rdy;
  assign bus.tw_valid   = tw_vld;
  assign bus.tw_data    = tw_vld ? buf_q : '0;
  assign bus.tw_count   = tw_vld ? cnt_q : '0;
  assign bus.dct_buffer = buf_q;
  assign bus.dct_count  = cnt_q;
  assign bus.busy       = (cnt_q != '0) || tw_vld;

endmodule
